aquila_device_axil_bridge: RTL and testbench

//  Converts the Aquila uncached device port (0xC000_0000-0xCFFF_FFFF) into a single-outstanding AXI4-Lite master.

---
 rtl/aquila_device_axil_bridge.sv | 213 +++++++++++++++++++++
 tb/tb_aquila_device_axil_bridge.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aquila_device_axil_bridge.sv
// Aquila uncached device port to AXI4-Lite master bridge.
// One request outstanding at a time. A bus timeout keeps a missing slave from
// hanging the core. Completion is signalled by a one-cycle ready pulse.
module aquila_device_axil_bridge #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     TIMEOUT_CYC = 1024,
    parameter logic [XLEN-1:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    // Device side (from the core's M_DEVICE_* port)
    input  logic                dev_strobe_i,
    input  logic [XLEN-1:0]     dev_addr_i,
    input  logic                dev_rw_i,
    input  logic [XLEN/8-1:0]   dev_byte_enable_i,
    input  logic [XLEN-1:0]     dev_data_i,
    output logic                dev_data_ready_o,
    output logic [XLEN-1:0]     dev_data_o,
    output logic                dev_error_o,
    // AXI4-Lite write address / data / response
    output logic [XLEN-1:0]     m_axi_awaddr,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [XLEN-1:0]     m_axi_wdata,
    output logic [XLEN/8-1:0]   m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    // AXI4-Lite read address / data
    output logic [XLEN-1:0]     m_axi_araddr,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [XLEN-1:0]     m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_reg,   state_next;
    logic                awvalid_reg, awvalid_next;
    logic                wvalid_reg,  wvalid_next;
    logic                bready_reg,  bready_next;
    logic                arvalid_reg, arvalid_next;
    logic                rready_reg,  rready_next;
    logic [XLEN-1:0]     awaddr_reg,  awaddr_next;
    logic [XLEN-1:0]     wdata_reg,   wdata_next;
    logic [XLEN/8-1:0]   wstrb_reg,   wstrb_next;
    logic [XLEN-1:0]     araddr_reg,  araddr_next;
    logic [XLEN-1:0]     rdata_reg,   rdata_next;
    logic                error_reg,   error_next;
    logic [31:0]         cnt_reg,     cnt_next;

    // Per-channel "still waiting for handshake" after this cycle
    logic                aw_pending;
    logic                w_pending;
    logic                ar_pending;
    logic                timeout_hit;

    assign aw_pending  = awvalid_reg & ~m_axi_awready;
    assign w_pending   = wvalid_reg  & ~m_axi_wready;
    assign ar_pending  = arvalid_reg & ~m_axi_arready;
    // Counter starts at 0 in the first bus cycle, so this fires in the
    // TIMEOUT_CYC-th cycle spent waiting on the slave.
    assign timeout_hit = (TIMEOUT_CYC != 0) && ((cnt_reg + 32'd1) == TIMEOUT_CYC);

    // Next-state and next-output logic for the request FSM
    always_comb begin
        state_next   = state_reg;
        awvalid_next = awvalid_reg;
        wvalid_next  = wvalid_reg;
        bready_next  = bready_reg;
        arvalid_next = arvalid_reg;
        rready_next  = rready_reg;
        awaddr_next  = awaddr_reg;
        wdata_next   = wdata_reg;
        wstrb_next   = wstrb_reg;
        araddr_next  = araddr_reg;
        rdata_next   = rdata_reg;
        error_next   = error_reg;
        cnt_next     = cnt_reg;

        case (state_reg)
            S_IDLE: begin
                cnt_next = 32'd0;
                if (dev_strobe_i) begin
                    if (dev_rw_i) begin
                        state_next   = S_WRITE;
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        awaddr_next  = dev_addr_i;
                        wdata_next   = dev_data_i;
                        wstrb_next   = dev_byte_enable_i;
                    end else begin
                        state_next   = S_READ;
                        arvalid_next = 1'b1;
                        araddr_next  = dev_addr_i;
                    end
                end
            end

            S_WRITE: begin
                cnt_next = cnt_reg + 32'd1;
                if (bready_reg && m_axi_bvalid) begin
                    // A response that lands on the timeout cycle still wins
                    state_next  = S_RESP;
                    bready_next = 1'b0;
                    if (m_axi_bresp != 2'b00) begin
                        error_next = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_next   = S_RESP;
                    awvalid_next = 1'b0;
                    wvalid_next  = 1'b0;
                    bready_next  = 1'b0;
                    error_next   = 1'b1;
                end else begin
                    awvalid_next = aw_pending;
                    wvalid_next  = w_pending;
                    bready_next  = ~aw_pending & ~w_pending;
                end
            end

            S_READ: begin
                cnt_next = cnt_reg + 32'd1;
                if (rready_reg && m_axi_rvalid) begin
                    state_next  = S_RESP;
                    rready_next = 1'b0;
                    if (m_axi_rresp != 2'b00) begin
                        rdata_next = ERR_DATA;
                        error_next = 1'b1;
                    end else begin
                        rdata_next = m_axi_rdata;
                    end
                end else if (timeout_hit) begin
                    state_next   = S_RESP;
                    arvalid_next = 1'b0;
                    rready_next  = 1'b0;
                    rdata_next   = ERR_DATA;
                    error_next   = 1'b1;
                end else begin
                    arvalid_next = ar_pending;
                    rready_next  = ~ar_pending;
                end
            end

            S_RESP: begin
                // Any strobe seen here is dropped; the core re-requests from IDLE
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= S_IDLE;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b0;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b0;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            araddr_reg  <= '0;
            rdata_reg   <= '0;
            error_reg   <= 1'b0;
            cnt_reg     <= 32'd0;
        end else begin
            state_reg   <= state_next;
            awvalid_reg <= awvalid_next;
            wvalid_reg  <= wvalid_next;
            bready_reg  <= bready_next;
            arvalid_reg <= arvalid_next;
            rready_reg  <= rready_next;
            awaddr_reg  <= awaddr_next;
            wdata_reg   <= wdata_next;
            wstrb_reg   <= wstrb_next;
            araddr_reg  <= araddr_next;
            rdata_reg   <= rdata_next;
            error_reg   <= error_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign dev_data_ready_o = (state_reg == S_RESP);
    assign dev_data_o       = rdata_reg;
    assign dev_error_o      = error_reg;

    assign m_axi_awaddr  = awaddr_reg;
    assign m_axi_awvalid = awvalid_reg;
    assign m_axi_wdata   = wdata_reg;
    assign m_axi_wstrb   = wstrb_reg;
    assign m_axi_wvalid  = wvalid_reg;
    assign m_axi_bready  = bready_reg;
    assign m_axi_araddr  = araddr_reg;
    assign m_axi_arvalid = arvalid_reg;
    assign m_axi_rready  = rready_reg;

endmodule

// File: tb/tb_aquila_device_axil_bridge.sv
// Self-checking bench for the Aquila device-port to AXI4-Lite bridge.
// A behavioural AXI4-Lite slave with programmable per-channel delays and a
// small word memory sits on the bus; expectations come from a separate
// reference memory plus the handshake timing rules of the bridge.
module tb_aquila_device_axil_bridge;

    localparam int          TMO     = 16;
    localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic        dev_strobe;
    logic [31:0] dev_addr;
    logic        dev_rw;
    logic [3:0]  dev_be;
    logic [31:0] dev_wdata;
    logic        dev_data_ready_o;
    logic [31:0] dev_data_o;
    logic        dev_error_o;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    int checks = 0;
    int errors = 0;

    aquila_device_axil_bridge #(
        .XLEN(32), .TIMEOUT_CYC(TMO), .ERR_DATA(ERR_VAL)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .dev_strobe_i(dev_strobe), .dev_addr_i(dev_addr), .dev_rw_i(dev_rw),
        .dev_byte_enable_i(dev_be), .dev_data_i(dev_wdata),
        .dev_data_ready_o(dev_data_ready_o), .dev_data_o(dev_data_o),
        .dev_error_o(dev_error_o),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- slave configuration (written by tests) ----------------
    int         aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    bit         slave_clr = 1'b0;

    // ---------------- slave observations (written by slave) -----------------
    int          aw_beats = 0, w_beats = 0, ar_beats = 0, b_beats = 0, r_beats = 0;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    int          pulses = 0;

    function automatic logic [31:0] init_word(input int i);
        return (i == 1) ? 32'h1234_5678 : (32'hC0DE_0000 + 32'(i * 17));
    endfunction

    // Reference model of slave memory contents
    logic [31:0] ref_mem [16];
    logic [31:0] exp_dev_data;
    bit          exp_err;

    // Count ready pulses, one per cycle high
    initial begin
        forever begin
            @(negedge clk);
            if (dev_data_ready_o === 1'b1) pulses++;
        end
    end

    // Behavioural AXI4-Lite slave, updated on the falling edge. Handshakes are
    // taken from the snapshot of the previous falling edge, which holds the
    // values the DUT saw at the rising edge in between.
    initial begin
        logic [31:0] mem [16];
        bit          p_aw, p_w, p_ar, p_b, p_r;
        logic [31:0] snap_awaddr, snap_wdata, snap_araddr;
        logic [3:0]  snap_wstrb;
        int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
        int          aw_pend, w_pend, ar_pend;
        for (int i = 0; i < 16; i++) mem[i] = init_word(i);
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
        p_aw = 0; p_w = 0; p_ar = 0; p_b = 0; p_r = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0;
        snap_awaddr = 0; snap_wdata = 0; snap_araddr = 0; snap_wstrb = 0;
        forever begin
            @(negedge clk);
            if (slave_clr) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
                m_axi_bvalid = 0; m_axi_rvalid = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
                aw_pend = 0; w_pend = 0; ar_pend = 0;
            end else begin
                if (p_aw) begin aw_beats++; aw_pend++; s_awaddr = snap_awaddr; end
                if (p_w)  begin w_beats++;  w_pend++;  s_wdata = snap_wdata; s_wstrb = snap_wstrb; end
                if (p_ar) begin ar_beats++; ar_pend++; s_araddr = snap_araddr; end
                if (p_b)  begin b_beats++;  m_axi_bvalid = 0; end
                if (p_r)  begin r_beats++;  m_axi_rvalid = 0; end

                if (m_axi_awvalid === 1'b1) begin
                    if (aw_wait >= aw_delay) m_axi_awready = 1; else begin m_axi_awready = 0; aw_wait++; end
                end else begin m_axi_awready = 0; aw_wait = 0; end
                if (m_axi_wvalid === 1'b1) begin
                    if (w_wait >= w_delay) m_axi_wready = 1; else begin m_axi_wready = 0; w_wait++; end
                end else begin m_axi_wready = 0; w_wait = 0; end
                if (m_axi_arvalid === 1'b1) begin
                    if (ar_wait >= ar_delay) m_axi_arready = 1; else begin m_axi_arready = 0; ar_wait++; end
                end else begin m_axi_arready = 0; ar_wait = 0; end

                if (!m_axi_bvalid && aw_pend > 0 && w_pend > 0) begin
                    if (b_wait >= b_delay) begin
                        m_axi_bvalid = 1; m_axi_bresp = bresp_cfg;
                        if (bresp_cfg == 2'b00) begin
                            for (int b = 0; b < 4; b++)
                                if (s_wstrb[b]) mem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
                        end
                        aw_pend--; w_pend--; b_wait = 0;
                    end else b_wait++;
                end
                if (!m_axi_rvalid && ar_pend > 0) begin
                    if (r_wait >= r_delay) begin
                        m_axi_rvalid = 1; m_axi_rresp = rresp_cfg;
                        m_axi_rdata = mem[s_araddr[5:2]];
                        ar_pend--; r_wait = 0;
                    end else r_wait++;
                end
            end
            p_aw = (m_axi_awvalid === 1'b1) && m_axi_awready;
            p_w  = (m_axi_wvalid  === 1'b1) && m_axi_wready;
            p_ar = (m_axi_arvalid === 1'b1) && m_axi_arready;
            p_b  = m_axi_bvalid && (m_axi_bready === 1'b1);
            p_r  = m_axi_rvalid && (m_axi_rready === 1'b1);
            snap_awaddr = m_axi_awaddr; snap_wdata = m_axi_wdata;
            snap_wstrb = m_axi_wstrb;   snap_araddr = m_axi_araddr;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_slave();
        slave_clr = 1'b1;
        tick();
        slave_clr = 1'b0;
        aw_delay = 0; w_delay = 0; ar_delay = 0; b_delay = 0; r_delay = 0;
        bresp_cfg = 2'b00; rresp_cfg = 2'b00;
    endtask

    // Issue one request and wait for its ready pulse. lat is the number of
    // cycles from the strobe cycle to the pulse (-1 if it never came).
    // Returns one cycle after the pulse.
    task automatic do_txn(input bit rw, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input int extra_cyc, input bit resp_strobe,
                          output int lat);
        dev_strobe = 1'b1; dev_rw = rw; dev_addr = addr; dev_wdata = data; dev_be = be;
        tick();
        dev_strobe = 1'b0;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            dev_strobe = (k == extra_cyc);
            if (k == extra_cyc) dev_rw = 1'b1;
            if (dev_data_ready_o === 1'b1) begin
                if (resp_strobe) begin dev_strobe = 1'b1; dev_rw = 1'b0; end
                lat = k;
                break;
            end
            tick();
        end
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL txn_wait: ready pulse never seen, got none within 200 cycles, required one");
        end
        tick();
        dev_strobe = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; dev_strobe = 0; dev_rw = 0; dev_addr = 0; dev_wdata = 0; dev_be = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        exp_dev_data = 32'd0; exp_err = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
             dev_data_ready_o, dev_error_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000000", {m_axi_awvalid, m_axi_wvalid,
                     m_axi_arvalid, m_axi_bready, m_axi_rready, dev_data_ready_o, dev_error_o});
        end
        checks++;
        if ({dev_data_o, m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_data: got data=%h awaddr=%h wdata=%h araddr=%h wstrb=%h required all 0",
                     dev_data_o, m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_wstrb);
        end
        $display("reset: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_read_basic();
        int lat;
        int ar0;
        ar0 = ar_beats;
        do_txn(1'b0, 32'hC000_0004, 32'd0, 4'd0, 0, 1'b0, lat);
        exp_dev_data = ref_mem[1];
        checks++;
        if (lat != 3) begin errors++; $display("FAIL read_basic_lat: got %0d required 3", lat); end
        checks++;
        if (dev_data_o !== 32'h1234_5678) begin
            errors++; $display("FAIL read_basic_data: got %h required 12345678", dev_data_o);
        end
        checks++;
        if (ar_beats - ar0 != 1 || s_araddr !== 32'hC000_0004) begin
            errors++; $display("FAIL read_basic_ar: got beats=%0d addr=%h required 1 C0000004", ar_beats - ar0, s_araddr);
        end
        $display("read  addr=C0000004 lat=%0d data=%h", lat, dev_data_o);
    endtask

    task automatic test_write_wready_early();
        int lat;
        int aw0, w0, p0;
        aw0 = aw_beats; w0 = w_beats; p0 = pulses;
        aw_delay = 2; w_delay = 0;
        do_txn(1'b1, 32'hC000_0010, 32'hA5A5_A5A5, 4'b0011, 0, 1'b0, lat);
        ref_mem[4][15:0] = 16'hA5A5;
        checks++;
        if (lat != 5) begin errors++; $display("FAIL write_early_lat: got %0d required 5", lat); end
        checks++;
        if (aw_beats - aw0 != 1 || w_beats - w0 != 1 || pulses - p0 != 1) begin
            errors++; $display("FAIL write_early_beats: got aw=%0d w=%0d pulses=%0d required 1 1 1",
                               aw_beats - aw0, w_beats - w0, pulses - p0);
        end
        checks++;
        if (s_awaddr !== 32'hC000_0010 || s_wdata !== 32'hA5A5_A5A5 || s_wstrb !== 4'b0011) begin
            errors++; $display("FAIL write_early_payload: got %h %h %b required C0000010 A5A5A5A5 0011",
                               s_awaddr, s_wdata, s_wstrb);
        end
        checks++;
        if (dev_data_o !== exp_dev_data) begin
            errors++; $display("FAIL write_keeps_data: got %h required %h", dev_data_o, exp_dev_data);
        end
        aw_delay = 0;
        $display("write addr=C0000010 data=A5A5A5A5 be=0011 lat=%0d", lat);
    endtask

    // Randomised mix of reads and writes, each issued the cycle after the
    // previous completion.
    task automatic test_back_to_back();
        int lat, exp_lat, idx, aw0, w0, ar0, mx;
        bit rw;
        logic [31:0] addr, data;
        logic [3:0]  be;
        for (int n = 0; n < 40; n++) begin
            rw = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 15);
            addr = 32'hC000_0000 | 32'(idx << 2);
            data = $urandom;
            be = 4'($urandom_range(1, 15));
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            ar_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
            r_delay = $urandom_range(0, 3);
            aw0 = aw_beats; w0 = w_beats; ar0 = ar_beats;
            do_txn(rw, addr, data, be, 0, 1'b0, lat);
            if (rw) begin
                mx = (aw_delay > w_delay) ? aw_delay : w_delay;
                exp_lat = 3 + mx + b_delay;
                for (int b = 0; b < 4; b++) if (be[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
                checks++;
                if (aw_beats - aw0 != 1 || w_beats - w0 != 1 || s_awaddr !== addr ||
                    s_wdata !== data || s_wstrb !== be) begin
                    errors++; $display("FAIL b2b_wpayload: got %0d/%0d %h %h %b required 1/1 %h %h %b",
                                       aw_beats - aw0, w_beats - w0, s_awaddr, s_wdata, s_wstrb, addr, data, be);
                end
            end else begin
                exp_lat = 3 + ar_delay + r_delay;
                exp_dev_data = ref_mem[idx];
                checks++;
                if (ar_beats - ar0 != 1 || s_araddr !== addr) begin
                    errors++; $display("FAIL b2b_ar: got %0d %h required 1 %h", ar_beats - ar0, s_araddr, addr);
                end
            end
            checks++;
            if (lat != exp_lat) begin errors++; $display("FAIL b2b_lat: got %0d required %0d", lat, exp_lat); end
            checks++;
            if (dev_data_o !== exp_dev_data || dev_error_o !== exp_err) begin
                errors++; $display("FAIL b2b_data: got %h err=%b required %h err=%b",
                                   dev_data_o, dev_error_o, exp_dev_data, exp_err);
            end
            $display("b2b %s addr=%h data=%h be=%b lat=%0d out=%h", rw ? "write" : "read ", addr, data, be, lat, dev_data_o);
        end
        clear_slave();
    endtask

    task automatic test_error_resp();
        int lat;
        bresp_cfg = 2'b10;
        do_txn(1'b1, 32'hC000_0014, 32'h0BAD_F00D, 4'b1111, 0, 1'b0, lat);
        exp_err = 1'b1;
        checks++;
        if (lat != 3 || dev_error_o !== 1'b1) begin
            errors++; $display("FAIL bresp_err: got lat=%0d err=%b required 3 1", lat, dev_error_o);
        end
        bresp_cfg = 2'b00;
        do_txn(1'b0, 32'hC000_0014, 32'd0, 4'd0, 0, 1'b0, lat);
        exp_dev_data = ref_mem[5];
        checks++;
        if (dev_data_o !== exp_dev_data || dev_error_o !== 1'b1) begin
            errors++; $display("FAIL okay_after_err: got %h err=%b required %h 1", dev_data_o, dev_error_o, exp_dev_data);
        end
        rresp_cfg = 2'b11;
        do_txn(1'b0, 32'hC000_0018, 32'd0, 4'd0, 0, 1'b0, lat);
        exp_dev_data = ERR_VAL;
        checks++;
        if (dev_data_o !== ERR_VAL || lat != 3) begin
            errors++; $display("FAIL rresp_err: got %h lat=%0d required %h 3", dev_data_o, lat, ERR_VAL);
        end
        rresp_cfg = 2'b00;
        $display("error responses: err=%b data=%h", dev_error_o, dev_data_o);
    endtask

    task automatic test_timeout();
        int lat, ar0;
        ar0 = ar_beats;
        ar_delay = 1000;
        do_txn(1'b0, 32'hC000_0020, 32'd0, 4'd0, 0, 1'b0, lat);
        checks++;
        if (lat != TMO + 1) begin errors++; $display("FAIL timeout_lat: got %0d required %0d", lat, TMO + 1); end
        checks++;
        if (dev_data_o !== ERR_VAL || dev_error_o !== 1'b1 || m_axi_arvalid !== 1'b0 ||
            m_axi_rready !== 1'b0 || ar_beats != ar0) begin
            errors++; $display("FAIL timeout_state: got data=%h err=%b arvalid=%b rready=%b beats=%0d required %h 1 0 0 0",
                               dev_data_o, dev_error_o, m_axi_arvalid, m_axi_rready, ar_beats - ar0, ERR_VAL);
        end
        clear_slave();
        // Slave accepts the address but answers long after the timeout
        r_delay = 30;
        do_txn(1'b0, 32'hC000_0024, 32'd0, 4'd0, 0, 1'b0, lat);
        begin
            int p0;
            p0 = pulses;
            repeat (25) tick();
            checks++;
            if (lat != TMO + 1 || pulses != p0 || dev_data_o !== ERR_VAL || m_axi_rvalid !== 1'b1) begin
                errors++; $display("FAIL late_rbeat: got lat=%0d extra=%0d data=%h rvalid=%b required %0d 0 %h 1",
                                   lat, pulses - p0, dev_data_o, m_axi_rvalid, TMO + 1, ERR_VAL);
            end
        end
        clear_slave();
        exp_dev_data = ERR_VAL;
        $display("timeout read lat=%0d data=%h err=%b", lat, dev_data_o, dev_error_o);
    endtask

    task automatic test_ignore_strobe();
        int lat, ar0, aw0, p0;
        bit stray;
        ar0 = ar_beats; aw0 = aw_beats; p0 = pulses;
        ar_delay = 5;
        do_txn(1'b0, 32'hC000_0008, 32'hFFFF_FFFF, 4'hF, 2, 1'b1, lat);
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (m_axi_awvalid !== 1'b0 || m_axi_arvalid !== 1'b0 || m_axi_wvalid !== 1'b0) stray = 1'b1;
            tick();
        end
        exp_dev_data = ref_mem[2];
        checks++;
        if (lat != 8 || dev_data_o !== exp_dev_data) begin
            errors++; $display("FAIL ignore_lat: got lat=%0d data=%h required 8 %h", lat, dev_data_o, exp_dev_data);
        end
        checks++;
        if (ar_beats - ar0 != 1 || aw_beats != aw0 || pulses - p0 != 1 || stray) begin
            errors++; $display("FAIL ignore_beats: got ar=%0d aw=%0d pulses=%0d stray=%b required 1 0 1 0",
                               ar_beats - ar0, aw_beats - aw0, pulses - p0, stray);
        end
        clear_slave();
        $display("ignored strobes: lat=%0d pulses=%0d", lat, pulses - p0);
    endtask

    task automatic test_reset_mid();
        int p0, lat;
        aw_delay = 10; w_delay = 10;
        p0 = pulses;
        dev_strobe = 1'b1; dev_rw = 1'b1; dev_addr = 32'hC000_0030; dev_wdata = 32'h1111_2222; dev_be = 4'hF;
        tick();
        dev_strobe = 1'b0;
        tick();
        checks++;
        if (m_axi_awvalid !== 1'b1) begin errors++; $display("FAIL mid_pre: got awvalid=%b required 1", m_axi_awvalid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, dev_data_ready_o, dev_error_o} !== 4'b0 || dev_data_o !== 32'd0) begin
            errors++; $display("FAIL mid_reset: got aw=%b w=%b rdy=%b err=%b data=%h required 0 0 0 0 0",
                               m_axi_awvalid, m_axi_wvalid, dev_data_ready_o, dev_error_o, dev_data_o);
        end
        repeat (20) tick();
        checks++;
        if (pulses != p0) begin errors++; $display("FAIL mid_nopulse: got %0d pulses required 0", pulses - p0); end
        clear_slave();
        do_txn(1'b0, 32'hC000_0030, 32'd0, 4'd0, 0, 1'b0, lat);
        checks++;
        if (lat != 3 || dev_data_o !== ref_mem[12] || dev_error_o !== 1'b0) begin
            errors++; $display("FAIL mid_after: got lat=%0d data=%h err=%b required 3 %h 0", lat, dev_data_o, dev_error_o, ref_mem[12]);
        end
        $display("reset mid-write then read: lat=%0d data=%h", lat, dev_data_o);
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_wready_early();
        test_back_to_back();
        test_error_resp();
        test_timeout();
        test_ignore_strobe();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
